// File: rtl/mul_err_stats_pkg.sv
// ---------------------------------------------------------------------------
// mul_err_pkg
//   Shared definitions for the multiplier error-statistics block:
//   default operand/accumulator widths, the counter width used for the
//   sample and error counters, and the controller state type.
// ---------------------------------------------------------------------------
package mul_err_pkg;

    // Operand width of the multipliers under comparison (products: 2*W+1).
    localparam int unsigned WIDTH_DEF = 8;

    // Width of the error-distance accumulator.
    localparam int unsigned ACC_W_DEF = 32;

    // Width of the window length, sample counter and error counter.
    localparam int unsigned CNT_W = 16;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage : mul_err_pkg

// File: rtl/mul_err_stats_if.sv
// ---------------------------------------------------------------------------
// mul_err_stats_if
//   Bundles the control, sample-stream and result-stream signals of
//   mul_err_stats.
//     start/num_samples        : window start pulse and window length N
//     in_valid/in_ready        : product-pair handshake
//     exact_p/approx_p         : exact and approximate products
//     res_valid/res_ready      : statistics handshake
//     sum_ed/err_cnt/max_ed    : window statistics
//     busy                     : block is not idle
//   Modport "slave" is the statistics block, "master" is the environment.
// ---------------------------------------------------------------------------
interface mul_err_stats_if #(
    parameter int unsigned WIDTH = mul_err_pkg::WIDTH_DEF,
    parameter int unsigned ACC_W = mul_err_pkg::ACC_W_DEF
);

    logic                          start;
    logic [mul_err_pkg::CNT_W-1:0] num_samples;
    logic                          in_valid;
    logic                          in_ready;
    logic [2*WIDTH:0]              exact_p;
    logic [2*WIDTH:0]              approx_p;
    logic                          res_valid;
    logic                          res_ready;
    logic [ACC_W-1:0]              sum_ed;
    logic [mul_err_pkg::CNT_W-1:0] err_cnt;
    logic [2*WIDTH:0]              max_ed;
    logic                          busy;

    modport slave (
        input  start,
        input  num_samples,
        input  in_valid,
        output in_ready,
        input  exact_p,
        input  approx_p,
        output res_valid,
        input  res_ready,
        output sum_ed,
        output err_cnt,
        output max_ed,
        output busy
    );

    modport master (
        output start,
        output num_samples,
        output in_valid,
        input  in_ready,
        output exact_p,
        output approx_p,
        input  res_valid,
        output res_ready,
        input  sum_ed,
        input  err_cnt,
        input  max_ed,
        input  busy
    );

endinterface : mul_err_stats_if

// File: rtl/mul_err_stats_abs_diff.sv
// ---------------------------------------------------------------------------
// abs_diff
//   Combinational unsigned absolute difference |a - b|.
//   Ports:
//     a_i, b_i : W-bit unsigned operands
//     y_o      : W-bit unsigned |a_i - b_i| (always representable in W bits)
// ---------------------------------------------------------------------------
module abs_diff #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        if (a_i >= b_i) begin
            y_o = a_i - b_i;
        end else begin
            y_o = b_i - a_i;
        end
    end

endmodule : abs_diff

// File: rtl/mul_err_stats.sv
// ---------------------------------------------------------------------------
// mul_err_stats
//   Compares a stream of exact/approximate multiplier products over a window
//   of N pairs and reports the sum of error distances (saturating), the
//   number of erroneous pairs (saturating) and the largest error distance.
//
//   Ports:
//     clk   : clock, rising-edge active
//     rst_n : asynchronous active-low reset
//     bus   : mul_err_stats_if.slave (start/N, pair stream, result stream)
//
//   Datapath: stage 1 registers |exact - approx| for each accepted pair,
//   stage 2 folds it into the statistics. The controller walks
//   IDLE -> ACCUM -> DRAIN -> REPORT -> IDLE; N = 0 skips straight to REPORT.
// ---------------------------------------------------------------------------
module mul_err_stats
    import mul_err_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_err_stats_if.slave    bus
);

    localparam int unsigned PW    = 2 * WIDTH + 1;
    // Sum is formed one bit wider than both addends so overflow is visible
    // even when the error distance is wider than the accumulator.
    localparam int unsigned SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    // Controller state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clear_stats;
    logic               accept;

    // Stage 1
    logic [PW-1:0]      ed_w;
    logic               s1_valid_q, s1_valid_d;
    logic [PW-1:0]      s1_ed_q, s1_ed_d;

    // Stage 2 statistics
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [PW-1:0]      max_q, max_d;
    logic [SUM_W-1:0]   sum_wide;

    abs_diff #(
        .W (PW)
    ) u_abs_diff (
        .a_i (bus.exact_p),
        .b_i (bus.approx_p),
        .y_o (ed_w)
    );

    assign accept = (state_q == ST_ACCUM) && bus.in_valid;

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        clear_stats = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d         = bus.num_samples;
                    cnt_d       = '0;
                    clear_stats = 1'b1;
                    state_d     = (bus.num_samples == '0) ? ST_REPORT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == (n_q - 1'b1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last pair sits in stage 1 for exactly this cycle and is
                // folded into the statistics on the edge that leaves DRAIN.
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage 1: error distance of the accepted pair
    // -----------------------------------------------------------------------
    always_comb begin
        s1_valid_d = accept;
        s1_ed_d    = accept ? ed_w : s1_ed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ed_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ed_q    <= s1_ed_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: statistics update
    // -----------------------------------------------------------------------
    assign sum_wide = {{(SUM_W - ACC_W){1'b0}}, sum_q}
                    + {{(SUM_W - PW){1'b0}}, s1_ed_q};

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        max_d = max_q;
        if (clear_stats) begin
            sum_d = '0;
            err_d = '0;
            max_d = '0;
        end else if (s1_valid_q) begin
            sum_d = (sum_wide > ACC_MAX) ? '1 : sum_wide[ACC_W-1:0];
            if ((s1_ed_q != '0) && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
            if (s1_ed_q > max_q) begin
                max_d = s1_ed_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= '0;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
            max_q <= max_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.res_valid = (state_q == ST_REPORT);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sum_ed    = sum_q;
    assign bus.err_cnt   = err_q;
    assign bus.max_ed    = max_q;

endmodule : mul_err_stats

// File: tb/tb_mul_err_stats.sv
// ---------------------------------------------------------------------------
// tb_mul_err_stats
//   Self-checking bench for mul_err_stats. A default instance (ACC_W=32)
//   runs table vectors, random windows and reset/start corner cases; a
//   second instance with ACC_W=8 exercises accumulator saturation.
// ---------------------------------------------------------------------------
module tb_mul_err_stats;

    logic clk;
    logic rst_n;

    mul_err_stats_if #(.WIDTH(8), .ACC_W(32)) bus ();
    mul_err_stats_if #(.WIDTH(8), .ACC_W(8))  b8  ();

    mul_err_stats #(.WIDTH(8), .ACC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mul_err_stats #(.WIDTH(8), .ACC_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pair stream for the current window.
    logic [16:0] pe [64];
    logic [16:0] pa [64];

    typedef struct packed {
        logic [15:0]       n;
        logic [3:0][16:0]  e;
        logic [3:0][16:0]  a;
        logic [31:0]       sum;
        logic [15:0]       err;
        logic [16:0]       mx;
    } vec_t;

    vec_t vt [4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int n,
                           input int e0, input int a0, input int e1, input int a1,
                           input int e2, input int a2, input int e3, input int a3,
                           input longint s, input int er, input int mx);
        vt[i].n      = n[15:0];
        vt[i].e[0]   = e0[16:0];
        vt[i].a[0]   = a0[16:0];
        vt[i].e[1]   = e1[16:0];
        vt[i].a[1]   = a1[16:0];
        vt[i].e[2]   = e2[16:0];
        vt[i].a[2]   = a2[16:0];
        vt[i].e[3]   = e3[16:0];
        vt[i].a[3]   = a3[16:0];
        vt[i].sum    = s[31:0];
        vt[i].err    = er[15:0];
        vt[i].mx     = mx[16:0];
    endtask

    // Reference: statistics of the first n pairs from plain arithmetic.
    // All distances are non-negative, so capping the total once equals a
    // saturating running sum.
    task automatic model(input int n, input int accw,
                         output longint s, output longint e, output longint mx);
        longint d;
        s = 0; e = 0; mx = 0;
        for (int i = 0; i < n; i++) begin
            d = (pe[i] > pa[i]) ? longint'(pe[i]) - longint'(pa[i])
                                : longint'(pa[i]) - longint'(pe[i]);
            s = s + d;
            if (d != 0) e = e + 1;
            if (d > mx) mx = d;
        end
        if (s > (longint'(1) << accw) - 1) s = (longint'(1) << accw) - 1;
        if (e > 65535) e = 65535;
    endtask

    // Runs one window on the default instance; must be called at a negedge
    // with the block idle. gap_pct: chance of an idle input cycle;
    // hold: cycles res_ready stays low in REPORT; noise: pulse start and
    // scramble num_samples while the block is busy.
    task automatic run_window(input int n, input int gap_pct, input int hold, input bit noise,
                              input longint xs, input longint xe, input longint xm,
                              input string tag);
        int idx, cyc, hs, rv, bad_ready, bad_hold;
        bit done;
        idx = 0; cyc = 0; hs = -1; rv = -1; bad_ready = 0; bad_hold = 0; done = 0;
        bus.start       = 1'b1;
        bus.num_samples = n[15:0];
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy_after_start"}, bus.busy, 1);
        while (!done && cyc < 400) begin
            if (bus.res_valid) begin
                rv   = cyc;
                done = 1'b1;
            end else begin
                if (bus.in_ready && idx >= n) bad_ready++;
                if (idx < n && int'($urandom_range(99, 0)) >= gap_pct) begin
                    bus.in_valid = 1'b1;
                    bus.exact_p  = pe[idx];
                    bus.approx_p = pa[idx];
                end else begin
                    bus.in_valid = 1'b0;
                    bus.exact_p  = 17'($urandom);
                    bus.approx_p = 17'($urandom);
                end
                if (bus.in_valid && bus.in_ready) begin
                    hs = cyc;
                    idx++;
                end
                if (noise) begin
                    bus.start       = 1'($urandom_range(1, 0));
                    bus.num_samples = 16'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, "_res_valid_seen"}, done, 1);
        check({tag, "_latency"}, (n == 0) ? rv : rv - hs, (n == 0) ? 0 : 2);
        check({tag, "_in_ready_after_N"}, bad_ready, 0);
        check({tag, "_sum_ed"}, bus.sum_ed, xs);
        check({tag, "_err_cnt"}, bus.err_cnt, xe);
        check({tag, "_max_ed"}, bus.max_ed, xm);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                bus.start       = 1'($urandom_range(1, 0));
                bus.num_samples = 16'($urandom);
            end
            @(negedge clk);
            if (!bus.res_valid || !bus.busy || bus.in_ready
                || longint'(bus.sum_ed) != xs || longint'(bus.err_cnt) != xe
                || longint'(bus.max_ed) != xm) bad_hold++;
        end
        bus.start     = 1'b0;
        check({tag, "_report_hold"}, bad_hold, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_idle_res_valid"}, bus.res_valid, 0);
        check({tag, "_retained_sum"}, bus.sum_ed, xs);
        check({tag, "_retained_max"}, bus.max_ed, xm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint s, e, mx;
        int     n;

        bus.start = 1'b0; bus.num_samples = '0; bus.in_valid = 1'b0;
        bus.exact_p = '0; bus.approx_p = '0; bus.res_ready = 1'b0;
        b8.start  = 1'b0; b8.num_samples  = '0; b8.in_valid  = 1'b0;
        b8.exact_p  = '0; b8.approx_p  = '0; b8.res_ready  = 1'b0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_sum_ed",    bus.sum_ed,    0);
        check("rst_err_cnt",   bus.err_cnt,   0);
        check("rst_max_ed",    bus.max_ed,    0);
        check("rst8_busy",     b8.busy,       0);

        // Table vectors (first one starts on the edge right after reset release)
        set_vec(0, 4, 100, 100, 100, 96,  50, 60, 0, 0,          14, 2, 10);
        set_vec(1, 0,   0,   0,   0,  0,   0,  0, 0, 0,           0, 0, 0);
        set_vec(2, 1, 65535, 0,   0,  0,   0,  0, 0, 0,       65535, 1, 65535);
        set_vec(3, 3,   0, 131071, 7, 7, 131071, 0, 0, 0,    262142, 2, 131071);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                pe[k] = vt[i].e[k];
                pa[k] = vt[i].a[k];
            end
            run_window(int'(vt[i].n), 0, 2, 1'b0,
                       longint'(vt[i].sum), longint'(vt[i].err), longint'(vt[i].mx),
                       $sformatf("vec%0d", i));
        end

        // Accumulator saturation on the ACC_W=8 instance
        begin
            int cyc;
            b8.start = 1'b1; b8.num_samples = 16'd3;
            @(negedge clk);
            b8.start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                b8.in_valid = 1'b1;
                b8.exact_p  = (k == 0) ? 17'd200 : (k == 1) ? 17'd50  : 17'd1000;
                b8.approx_p = (k == 0) ? 17'd100 : (k == 1) ? 17'd150 : 17'd900;
                @(negedge clk);
            end
            b8.in_valid = 1'b0;
            cyc = 0;
            while (!b8.res_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("sat8_res_valid_seen", b8.res_valid, 1);
            check("sat8_latency", cyc, 1);
            check("sat8_sum_ed",  b8.sum_ed,  255);
            check("sat8_err_cnt", b8.err_cnt, 3);
            check("sat8_max_ed",  b8.max_ed,  100);
            b8.res_ready = 1'b1;
            @(negedge clk);
            b8.res_ready = 1'b0;
            check("sat8_idle", b8.busy, 0);
        end

        // Same 5 pairs gap-free, then with random gaps and a stalled consumer
        for (int k = 0; k < 5; k++) begin
            pe[k] = 17'($urandom);
            pa[k] = ($urandom_range(3, 0) == 0) ? pe[k] : 17'($urandom);
        end
        model(5, 32, s, e, mx);
        run_window(5, 0,  0,  1'b0, s, e, mx, "n5_nogap");
        run_window(5, 50, 10, 1'b0, s, e, mx, "n5_gaps");

        // start pulses and num_samples changes while busy are ignored
        for (int k = 0; k < 6; k++) begin
            pe[k] = 17'($urandom);
            pa[k] = 17'($urandom);
        end
        model(6, 32, s, e, mx);
        run_window(6, 30, 5, 1'b1, s, e, mx, "start_noise");

        // Random windows
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(20, 1));
            for (int k = 0; k < n; k++) begin
                pe[k] = 17'($urandom);
                pa[k] = ($urandom_range(9, 0) < 3) ? pe[k]
                      : (r % 2 == 0) ? 17'($urandom) : pe[k] ^ 17'($urandom_range(255, 1));
            end
            model(n, 32, s, e, mx);
            run_window(n, (r % 2) * 40, r, r >= 4, s, e, mx, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset mid-window, then a fresh start right after release
        bus.start = 1'b1; bus.num_samples = 16'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.exact_p = 17'd10; bus.approx_p = 17'd3;
        @(negedge clk);
        bus.exact_p = 17'd40; bus.approx_p = 17'd50;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("midrst_pre_sum", bus.sum_ed, 7);
        check("midrst_pre_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  bus.in_ready,  0);
        check("midrst_res_valid", bus.res_valid, 0);
        check("midrst_busy",      bus.busy,      0);
        check("midrst_sum_ed",    bus.sum_ed,    0);
        check("midrst_err_cnt",   bus.err_cnt,   0);
        check("midrst_max_ed",    bus.max_ed,    0);
        @(negedge clk);
        rst_n = 1'b1;
        pe[0] = 17'd65535; pa[0] = 17'd0;
        run_window(1, 0, 0, 1'b0, 65535, 1, 65535, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mul_err_stats
